// File: rtl/seven_seg_scan_driver.sv
// Four-digit common-anode 7-segment scan driver with per-slot blanking and
// frame-boundary double buffering of the displayed value.
//
// state   | meaning
// OFF     | display disabled, counter and digit index held at 0
// BLANK   | first BLANK cycles of a digit slot, all anodes off
// ON      | rest of the slot, digit idx driven from the display register
module seven_seg_scan_driver #(
  parameter int SCAN_DIV = 20000,
  parameter int BLANK    = 1000,
  parameter int CNT_W    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [3:0]  dp_in,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam logic [1:0] ST_OFF   = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       idx_q, idx_d;
  logic [19:0]      disp_q, disp_d;     // {dp[3:0], digits[15:0]}
  logic [19:0]      shadow_q, shadow_d;
  logic             pend_q, pend_d;
  logic             boundary;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             dp_q, dp_d;
  logic             fs_q, fs_d;
  logic [3:0]       nib;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    state_d  = state_q;
    boundary = 1'b0;
    if (!enable) begin
      cnt_d   = '0;
      idx_d   = 2'd0;
      state_d = ST_OFF;
    end else if (state_q == ST_OFF) begin
      cnt_d    = '0;
      idx_d    = 2'd0;
      boundary = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      idx_d    = idx_q + 2'd1;
      boundary = (idx_q == 2'd3);
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
    if (enable) state_d = (cnt_d < CNT_BLANK) ? ST_BLANK : ST_ON;
  end

  // A load coinciding with a boundary bypasses the shadow so it shows this frame.
  always_comb begin
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (load) begin
      shadow_d = {dp_in, digits_in};
      pend_d   = 1'b1;
    end
    if (boundary) begin
      if (load)        disp_d = {dp_in, digits_in};
      else if (pend_q) disp_d = shadow_q;
      pend_d = 1'b0;
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    nib = disp_q[3:0];
      2'd1:    nib = disp_q[7:4];
      2'd2:    nib = disp_q[11:8];
      default: nib = disp_q[15:12];
    endcase
  end

  // enable low forces dark outputs on the very next edge, not one cycle later.
  always_comb begin
    an_d = 4'b1111;
    seg_d = 7'b1111111;
    dp_d = 1'b1;
    fs_d = 1'b0;
    if (enable && state_q == ST_ON) begin
      an_d  = ~(4'b0001 << idx_q);
      seg_d = decode(nib);
      dp_d  = ~disp_q[16 + idx_q];
    end
    if (enable) fs_d = (state_q != ST_OFF) && (cnt_q == '0) && (idx_q == 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_OFF;
      cnt_q    <= '0;
      idx_q    <= 2'd0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      an_q     <= 4'b1111;
      seg_q    <= 7'b1111111;
      dp_q     <= 1'b1;
      fs_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      fs_q     <= fs_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule
